// File: rtl/par_parameter.sv
// rtl/par_parameter.sv - shared width parameters and FSM state type for mac_unpack_div
package par_parameter;
    localparam int par   = 7;
    localparam int W     = par + 1;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in one dividend bit, trial-subtract divisor
module div_step
    import par_parameter::*;
(
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] B,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] t;
    logic [W:0] diff;

    // rem < B on entry, so the shifted value fits W+1 bits and the difference fits W bits
    assign t        = {rem, bit_in};
    assign diff     = t - {1'b0, B};
    assign q_bit    = (t >= {1'b0, B});
    assign rem_next = q_bit ? diff[W-1:0] : t[W-1:0];
endmodule

// File: rtl/mac_unpack_div.sv
// rtl/mac_unpack_div.sv - recovers A and C from A*B+C and B with a bit-serial restoring divider
module mac_unpack_div
    import par_parameter::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] DATA_IN,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   A_OUT,
    output logic [W-1:0]   C_OUT,
    output logic           div_zero,
    output logic           ovf
);
    div_state_t       state, state_next;
    logic [W-1:0]     rem, q, b_reg;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     rem_next;
    logic             q_bit;
    logic             accept, b_zero, hi_ovf, last_step;

    assign accept    = in_valid && in_ready;
    assign b_zero    = (B == '0);
    assign hi_ovf    = (DATA_IN[2*W-1:W] >= B);
    assign last_step = (cnt == CNT_W'(1));

    div_step u_div_step (
        .rem      (rem),
        .bit_in   (q[W-1]),
        .B        (b_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                if (accept)
                    state_next = (b_zero || hi_ovf) ? DONE : CALC;
            end
            CALC: if (last_step) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            q        <= '0;
            b_reg    <= '0;
            cnt      <= '0;
            A_OUT    <= '0;
            C_OUT    <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    div_zero <= 1'b0;
                    ovf      <= 1'b0;
                    b_reg    <= B;
                    rem      <= DATA_IN[2*W-1:W];
                    q        <= DATA_IN[W-1:0];
                    cnt      <= CNT_W'(W);
                    // error results skip CALC and publish the saturated quotient directly
                    if (b_zero) begin
                        div_zero <= 1'b1;
                        A_OUT    <= '1;
                        C_OUT    <= '0;
                    end else if (hi_ovf) begin
                        ovf      <= 1'b1;
                        A_OUT    <= '1;
                        C_OUT    <= '0;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    q   <= {q[W-2:0], q_bit};
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        A_OUT <= {q[W-2:0], q_bit};
                        C_OUT <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_unpack_div.sv
// tb/tb_mac_unpack_div.sv - directed self-checking bench for mac_unpack_div (W=8)
module tb_mac_unpack_div;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] DATA_IN;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  A_OUT;
    logic [7:0]  C_OUT;
    logic        div_zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    mac_unpack_div dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DATA_IN   (DATA_IN),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_OUT     (A_OUT),
        .C_OUT     (C_OUT),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [15:0] d, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        DATA_IN  = d;
        B        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        wait_edges(1);
        check({tag, "_taken_valid"}, out_valid, 1'b0);
        check({tag, "_taken_ready"}, in_ready, 1'b1);
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] c,
                                input logic dz, input logic ov);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_a"}, A_OUT, a);
        check({tag, "_c"}, C_OUT, c);
        check({tag, "_div_zero"}, div_zero, dz);
        check({tag, "_ovf"}, ovf, ov);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        DATA_IN   = '0;
        B         = '0;
        out_ready = 1'b0;

        wait_edges(2);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_a", A_OUT, 8'h00);
        check("rst_c", C_OUT, 8'h00);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_release_ready", in_ready, 1'b1);

        // 1234 = 12*100 + 34, result appears exactly after edge 8
        start(16'd1234, 8'd100);
        check("t1_busy_ready", in_ready, 1'b0);
        wait_edges(7);
        check("t1_early_valid", out_valid, 1'b0);
        wait_edges(1);
        check_result("t1", 8'd12, 8'd34, 1'b0, 1'b0);

        // consumer stalls while a new request is offered
        in_valid = 1'b1;
        DATA_IN  = 16'd77;
        B        = 8'd10;
        for (int i = 0; i < 5; i++) begin
            wait_edges(1);
            check("hold_valid", out_valid, 1'b1);
            check("hold_a", A_OUT, 8'd12);
            check("hold_c", C_OUT, 8'd34);
            check("hold_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        take("t1");
        check("t1_after_take_a", A_OUT, 8'd12);

        start(16'hFEFF, 8'd255);
        wait_edges(8);
        check_result("t2", 8'd255, 8'd254, 1'b0, 1'b0);
        take("t2");

        start(16'd500, 8'd0);
        wait_edges(1);
        check_result("t3_dz", 8'hFF, 8'h00, 1'b1, 1'b0);
        take("t3");

        start(16'h6400, 8'd100);
        wait_edges(1);
        check_result("t4_ovf", 8'hFF, 8'h00, 1'b0, 1'b1);
        take("t4");

        // reset lands between CALC iterations 2 and 3
        start(16'd1234, 8'd100);
        wait_edges(2);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_ready", in_ready, 1'b0);
        wait_edges(2);
        check("rst_mid_a", A_OUT, 8'h00);
        check("rst_mid_flags", {div_zero, ovf}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        wait_edges(8);
        check("rst_mid_no_valid", out_valid, 1'b0);
        check("rst_mid_ready_again", in_ready, 1'b1);

        start(16'd77, 8'd10);
        wait_edges(7);
        check("t5_early_valid", out_valid, 1'b0);
        wait_edges(1);
        check_result("t5", 8'd7, 8'd7, 1'b0, 1'b0);
        take("t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
